// File: rtl/sdf_sched_pkg.sv
// Shared types and helpers for the burst-locking SDF flux scheduler.
// Optional feature macro used by the top: SDF_SCHED_STARVE_MON_EN.
package sdf_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Width of a flux index; a single flux still gets a one-bit tag.
  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // First set bit of req[0 +: flux] scanning ptr, ptr+1, ... and wrapping at flux.
  // Returns ptr when nothing is requested (caller qualifies with |req).
  // The loop runs downward so the candidate closest to ptr is written last.
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int flux);
    int idx;
    int pick;
    pick = ptr;
    for (int k = 31; k >= 0; k--) begin
      if (k < flux) begin
        idx = ptr + k;
        if (idx >= flux) idx = idx - flux;
        if (req[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdf_rr_picker.sv
// Combinational rotate-priority picker: first requesting flux at or after i_ptr.
module sdf_rr_picker
  import sdf_sched_pkg::*;
#(
  parameter int FLUX  = 2,
  parameter int TAG_W = 1
) (
  input  logic [FLUX-1:0]  i_req,
  input  logic [TAG_W-1:0] i_ptr,
  output logic             o_any,
  output logic [TAG_W-1:0] o_idx
);

  logic [31:0] w_req_ext;
  int          w_pick;

  assign w_req_ext = 32'(i_req);
  assign w_pick    = rr_pick(w_req_ext, int'(i_ptr), FLUX);
  assign o_any     = |i_req;
  assign o_idx     = w_pick[TAG_W-1:0];

endmodule

// File: rtl/sdf_flux_scheduler.sv
// Burst-locking round-robin scheduler: locks one flux for BURST firings,
// drives that flux's FIFO read strobes, and releases early after HOLD_MAX
// consecutive starved-input cycles. Full only backpressures, never releases.
// Define SDF_SCHED_STARVE_MON_EN to add per-flux wait counters, the starve
// flags, and starving-first selection in IDLE.
module sdf_flux_scheduler
  import sdf_sched_pkg::*;
#(
  parameter int  FLUX         = 2,
  parameter int  PORTS        = 2,
  parameter int  BURST        = 4,
  parameter int  HOLD_MAX     = 3,
  parameter int  STARVE_LIMIT = 16,
  localparam int TAG_W        = tag_w(FLUX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLUX*PORTS-1:0] empty,
  input  logic                  full,
  output logic [FLUX*PORTS-1:0] read,
  output logic                  grant_valid,
  output logic [TAG_W-1:0]      grant_tag,
  output logic                  fire,
  output logic                  burst_done,
  output logic [FLUX-1:0]       starve
);

  localparam int BURST_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int HOLD_W  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  genvar gi;

  state_t             r_state, w_state_next;
  logic [TAG_W-1:0]   r_cur, w_cur_next;
  logic [TAG_W-1:0]   r_rr_ptr, w_rr_next;
  logic [TAG_W-1:0]   w_cur_inc;
  logic [BURST_W-1:0] r_burst_cnt, w_burst_next;
  logic [HOLD_W-1:0]  r_stall_cnt, w_stall_next;
  logic [FLUX-1:0]    w_ready;
  logic [FLUX-1:0]    w_starve;
  logic [FLUX-1:0]    w_pick_req;
  logic [TAG_W-1:0]   w_pick_ptr, w_pick_idx;
  logic               w_pick_any, w_take, w_cur_ready;
  logic               w_fire, w_done;

  // A flux is ready when every one of its input FIFOs holds a token.
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_ready
      assign w_ready[gi] = ~|empty[gi*PORTS +: PORTS];
    end
  endgenerate

  assign w_cur_ready = w_ready[r_cur];
  assign w_cur_inc   = (r_cur == TAG_W'(FLUX - 1)) ? '0 : r_cur + 1'b1;
  assign w_take      = (r_state == IDLE) && w_pick_any && !full;

`ifdef SDF_SCHED_STARVE_MON_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [FLUX-1:0] w_starve_req;

  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_wait
      logic [WAIT_W-1:0] r_wait;
      // Count cycles flux gi is ready but not being served; its grant clears it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wait <= '0;
        end else if (w_take && (w_pick_idx == TAG_W'(gi))) begin
          r_wait <= '0;
        end else if (w_ready[gi] && !((r_state == LOCK) && (r_cur == TAG_W'(gi)))
                     && (r_wait < WAIT_W'(STARVE_LIMIT))) begin
          r_wait <= r_wait + 1'b1;
        end
      end
      assign w_starve[gi] = (r_wait >= WAIT_W'(STARVE_LIMIT));
    end
  endgenerate

  // Starving ready fluxes pre-empt round-robin; lowest index wins among them.
  assign w_starve_req = w_starve & w_ready;
  assign w_pick_req   = (|w_starve_req) ? w_starve_req : w_ready;
  assign w_pick_ptr   = (|w_starve_req) ? '0 : r_rr_ptr;
`else
  assign w_starve   = '0;
  assign w_pick_req = w_ready;
  assign w_pick_ptr = r_rr_ptr;
`endif

  sdf_rr_picker #(
    .FLUX  (FLUX),
    .TAG_W (TAG_W)
  ) u_picker (
    .i_req (w_pick_req),
    .i_ptr (w_pick_ptr),
    .o_any (w_pick_any),
    .o_idx (w_pick_idx)
  );

  // Grant, burst and stall bookkeeping; fire is Mealy on the registered owner.
  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_rr_next    = r_rr_ptr;
    w_burst_next = r_burst_cnt;
    w_stall_next = r_stall_cnt;
    w_fire       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_cur_next   = w_pick_idx;
          w_burst_next = BURST_W'(BURST - 1);
          w_stall_next = '0;
          w_state_next = LOCK;
        end
      end
      LOCK: begin
        if (w_cur_ready && !full) begin
          w_fire       = 1'b1;
          w_stall_next = '0;
          if (r_burst_cnt == '0) begin
            w_done       = 1'b1;
            w_rr_next    = w_cur_inc;
            w_state_next = IDLE;
          end else begin
            w_burst_next = r_burst_cnt - 1'b1;
          end
        end else if (!w_cur_ready) begin
          // Inputs dried up: give up the grant after HOLD_MAX such cycles.
          if (r_stall_cnt == HOLD_W'(HOLD_MAX - 1)) begin
            w_rr_next    = w_cur_inc;
            w_state_next = IDLE;
          end else begin
            w_stall_next = r_stall_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur       <= w_cur_next;
      r_rr_ptr    <= w_rr_next;
      r_burst_cnt <= w_burst_next;
      r_stall_cnt <= w_stall_next;
    end
  end

  // Only the locked flux's ports are strobed, and only on a firing.
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_read
      assign read[gi*PORTS +: PORTS] = {PORTS{w_fire && (r_cur == TAG_W'(gi))}};
    end
  endgenerate

  assign grant_valid = (r_state == LOCK);
  assign grant_tag   = (r_state == LOCK) ? r_cur : '0;
  assign fire        = w_fire;
  assign burst_done  = w_done;
  assign starve      = w_starve;

endmodule

// File: tb/tb_sdf_flux_scheduler.sv
// Scoreboard bench for sdf_flux_scheduler: a transaction-level model predicts
// each cycle's grant/fire outcome from the scheduling rules; a monitor compares
// on the falling edge. Honours SDF_SCHED_STARVE_MON_EN when defined.
module tb_sdf_flux_scheduler;

  localparam int FLUX         = 2;
  localparam int PORTS        = 2;
  localparam int BURST        = 4;
  localparam int HOLD_MAX     = 3;
  localparam int STARVE_LIMIT = 16;
  localparam int NB           = FLUX * PORTS;
`ifdef SDF_SCHED_STARVE_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic [NB-1:0]   empty = '0;
  logic            full  = 1'b0;
  logic [NB-1:0]   read;
  logic            grant_valid;
  logic [0:0]      grant_tag;
  logic            fire;
  logic            burst_done;
  logic [FLUX-1:0] starve;

  always #5 clk = ~clk;

  sdf_flux_scheduler #(
    .FLUX         (FLUX),
    .PORTS        (PORTS),
    .BURST        (BURST),
    .HOLD_MAX     (HOLD_MAX),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .empty       (empty),
    .full        (full),
    .read        (read),
    .grant_valid (grant_valid),
    .grant_tag   (grant_tag),
    .fire        (fire),
    .burst_done  (burst_done),
    .starve      (starve)
  );

  typedef struct {
    bit              gv;
    int              tag;
    bit              fire;
    logic [FLUX-1:0] starve;
  } cyc_t;

  typedef struct {
    int            tag;
    logic [NB-1:0] rd;
    bit            done;
  } fire_t;

  cyc_t  cyc_q[$];
  fire_t fire_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Model state: who owns the actor, firings still owed, starved-cycle run,
  // where the next round-robin search starts, and per-flux waiting time.
  bit m_locked;
  int m_owner;
  int m_left;
  int m_stalls;
  int m_next;
  int m_wait[FLUX];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_left   = 0;
    m_stalls = 0;
    m_next   = 0;
    for (int f = 0; f < FLUX; f++) m_wait[f] = 0;
  endtask

  // Predict this cycle's outputs from the model state and inputs, then advance.
  task automatic model_eval(input bit rs, input logic [NB-1:0] em, input bit fu);
    bit    rdy[FLUX];
    bit    any_rdy;
    cyc_t  c;
    fire_t x;
    bit    old_locked;
    int    old_owner;
    int    chosen;
    bit    took;
    any_rdy = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      rdy[f] = 1'b1;
      for (int p = 0; p < PORTS; p++) if (em[f*PORTS+p]) rdy[f] = 1'b0;
      if (rdy[f]) any_rdy = 1'b1;
    end
    c.gv   = m_locked;
    c.tag  = m_owner;
    c.fire = 1'b0;
    for (int f = 0; f < FLUX; f++) c.starve[f] = MON && (m_wait[f] >= STARVE_LIMIT);
    old_locked = m_locked;
    old_owner  = m_owner;
    took       = 1'b0;
    chosen     = -1;
    if (!m_locked) begin
      if (!fu && any_rdy) begin
        if (MON) begin
          for (int f = FLUX - 1; f >= 0; f--) if (rdy[f] && c.starve[f]) chosen = f;
        end
        if (chosen < 0) begin
          for (int k = FLUX - 1; k >= 0; k--) if (rdy[(m_next + k) % FLUX]) chosen = (m_next + k) % FLUX;
        end
        took     = 1'b1;
        m_locked = 1'b1;
        m_owner  = chosen;
        m_left   = BURST;
        m_stalls = 0;
      end
    end else if (rdy[m_owner] && !fu) begin
      c.fire = 1'b1;
      x.tag  = m_owner;
      x.rd   = '0;
      for (int p = 0; p < PORTS; p++) x.rd[m_owner*PORTS+p] = 1'b1;
      m_left--;
      m_stalls = 0;
      x.done   = (m_left == 0);
      if (x.done) begin
        m_locked = 1'b0;
        m_next   = (m_owner + 1) % FLUX;
      end
      fire_q.push_back(x);
    end else if (!rdy[m_owner]) begin
      m_stalls++;
      if (m_stalls == HOLD_MAX) begin
        m_locked = 1'b0;
        m_next   = (m_owner + 1) % FLUX;
      end
    end
    if (MON) begin
      for (int f = 0; f < FLUX; f++) begin
        if (took && chosen == f) m_wait[f] = 0;
        else if (rdy[f] && !(old_locked && old_owner == f) && m_wait[f] < STARVE_LIMIT) m_wait[f]++;
      end
    end
    cyc_q.push_back(c);
    if (rs) model_reset();
  endtask

  task automatic step(input bit rs, input logic [NB-1:0] em, input bit fu);
    @(posedge clk);
    #1;
    rst   = rs;
    empty = em;
    full  = fu;
    model_eval(rs, em, fu);
  endtask

  function automatic logic [NB-1:0] rand_empty();
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = ($urandom_range(0, 5) == 0);
    return r;
  endfunction

  // Monitor: per-cycle grant state plus one scoreboard pop per observed firing.
  initial begin
    cyc_t  c;
    fire_t x;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("grant_valid", int'(grant_valid), int'(c.gv));
        if (c.gv) chk("grant_tag", int'(grant_tag), c.tag);
        chk("fire", int'(fire), int'(c.fire));
        chk("starve", int'(starve), int'(c.starve));
        if (fire) begin
          chk("fire_q_depth", fire_q.size(), 1);
          if (fire_q.size() > 0) begin
            x = fire_q.pop_front();
            $display("[TB] t=%0t fire tag=%0d read=%b burst_done=%b (exp tag=%0d read=%b done=%b)",
                     $time, grant_tag, read, burst_done, x.tag, x.rd, x.done);
            chk("fire_tag", int'(grant_tag), x.tag);
            chk("read", int'(read), int'(x.rd));
            chk("burst_done", int'(burst_done), int'(x.done));
          end
        end else begin
          chk("idle_read", int'(read), 0);
          chk("idle_burst_done", int'(burst_done), 0);
          chk("pending_fire", fire_q.size(), 0);
          fire_q.delete();
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    model_reset();
    // Reset held with all inputs ready.
    repeat (3) step(1'b1, '0, 1'b0);
    // Free-running: alternating full bursts of tag0 and tag1.
    repeat (20) step(1'b0, '0, 1'b0);
    // Backpressure after the second firing of tag0.
    repeat (2) step(1'b1, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1);
    repeat (12) step(1'b0, '0, 1'b0);
    // Flux0 starves after two firings: early release to tag1.
    step(1'b1, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (4) step(1'b0, 4'b0001, 1'b0);
    repeat (14) step(1'b0, '0, 1'b0);
    // Reset on the second firing of tag1; next grant must be tag0.
    step(1'b1, '0, 1'b0);
    repeat (7) step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b0);
`ifdef SDF_SCHED_STARVE_MON_EN
    // Flux1 waits behind a backpressured flux0 until flagged starving.
    step(1'b1, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (18) step(1'b0, '0, 1'b1);
    repeat (12) step(1'b0, '0, 1'b0);
`endif
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), rand_empty(), ($urandom_range(0, 4) == 0));
    end
    repeat (2) @(posedge clk);
    #1;
    chk("leftover_cycles", cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
